multdiv_ctrl: RTL and testbench

Iterative signed 32-bit multiply/divide unit for the simple processor. It accepts a one-cycle `ctrl_MULT` or `ctrl_DIV` pulse from the pipeline and latches both operands. It then sequences a shared shift/add datapath for 32 iterations and returns a 32-bit result with a one-cycle ready pulse and an exception flag. The processor stalls on `busy` and writes `data_result` back on `data_resultRDY`.

---
 rtl/multdiv_pkg.sv | 20 ++
 rtl/multdiv_dp.sv | 64 ++++++
 rtl/multdiv_ctrl.sv | 139 +++++++++++++
 tb/tb_multdiv_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Feature macro MULTDIV_EARLY_ZERO_EN is consumed by multdiv_ctrl.
package multdiv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } state_t;

   typedef enum logic {
      OP_MULT,
      OP_DIV
   } op_t;

   localparam int ITER = 32;
   localparam int CNT_W = $clog2(ITER);
   localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/multdiv_dp.sv
// Shared shift/add datapath: 64-bit product or remainder/quotient pair
// built around one 33-bit adder/subtractor.
module multdiv_dp
   import multdiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             zero,
   input  op_t              op,
   input  logic [WIDTH-1:0] amag,
   input  logic [WIDTH-1:0] bmag,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [WIDTH-1:0] m;
   logic [WIDTH:0]   x;
   logic [WIDTH:0]   y;
   logic [WIDTH:0]   sum;
   logic             cin;
   logic             qbit;

   // Divide subtracts as x + ~m + 1; bit WIDTH of the sum is the borrow.
   always_comb begin
      x   = {1'b0, hi};
      y   = lo[0] ? {1'b0, m} : '0;
      cin = 1'b0;
      if (op == OP_DIV) begin
         x   = {hi, lo[WIDTH-1]};
         y   = ~{1'b0, m};
         cin = 1'b1;
      end
      sum  = x + y + {{WIDTH{1'b0}}, cin};
      qbit = ~sum[WIDTH];
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         hi <= '0;
         lo <= '0;
         m  <= '0;
      end else if (load) begin
         hi <= '0;
         if (zero)
            lo <= '0;
         else
            lo <= (op == OP_MULT) ? bmag : amag;
         m  <= (op == OP_MULT) ? amag : bmag;
      end else if (step) begin
         if (op == OP_MULT) begin
            hi <= sum[WIDTH:1];
            lo <= {sum[0], lo[WIDTH-1:1]};
         end else begin
            hi <= qbit ? sum[WIDTH-1:0] : x[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], qbit};
         end
      end
   end

endmodule

// File: rtl/multdiv_ctrl.sv
// Signed 32-bit iterative multiply/divide controller: FSM, signs, fix-up.
// Define MULTDIV_EARLY_ZERO_EN to short-circuit zero operands in one cycle.
module multdiv_ctrl
   import multdiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   state_t           state;
   state_t           state_n;
   op_t              op;
   op_t              op_in;
   op_t              op_cur;
   logic [CNT_W-1:0] cnt;
   logic             sa;
   logic             sb;
   logic             dz;
   logic             neg;
   logic             start;
   logic             dz_in;
   logic             ez_in;
   logic             load;
   logic             step;
   logic             zero;
   logic             exc;
   logic [WIDTH-1:0] amag;
   logic [WIDTH-1:0] bmag;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] res;

   assign start  = ctrl_MULT | ctrl_DIV;
   assign op_in  = ctrl_MULT ? OP_MULT : OP_DIV;
   assign op_cur = (state == IDLE) ? op_in : op;
   assign busy   = (state != IDLE);

   assign amag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign bmag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

   assign dz_in = (op_in == OP_DIV) && (data_operandB == '0);

`ifdef MULTDIV_EARLY_ZERO_EN
   assign ez_in = (op_in == OP_MULT)
                ? ((data_operandA == '0) || (data_operandB == '0))
                : ((data_operandA == '0) && (data_operandB != '0));
`else
   assign ez_in = 1'b0;
`endif

   always_comb begin
      state_n = state;
      load    = 1'b0;
      step    = 1'b0;
      zero    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               zero    = dz_in | ez_in;
               state_n = (dz_in | ez_in) ? FIX : RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == CNT_W'(ITER - 1))
               state_n = FIX;
         end
         FIX:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Magnitude result is in lo; hi holds the upper product word.
   always_comb begin
      neg = sa ^ sb;
      res = neg ? -lo : lo;
      if (op == OP_MULT)
         exc = (hi != '0) | (lo[WIDTH-1] & ~(neg & (lo == INT_MIN)));
      else
         exc = dz | ((lo == INT_MIN) & ~neg);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state          <= IDLE;
         cnt            <= '0;
         op             <= OP_MULT;
         sa             <= 1'b0;
         sb             <= 1'b0;
         dz             <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         state          <= state_n;
         data_resultRDY <= (state == FIX);
         if (load) begin
            op  <= op_in;
            sa  <= data_operandA[WIDTH-1];
            sb  <= data_operandB[WIDTH-1];
            dz  <= dz_in;
            cnt <= '0;
         end else if (step) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (state == FIX) begin
            data_result    <= res;
            data_exception <= exc;
         end
      end
   end

   multdiv_dp #(
      .WIDTH(WIDTH)
   ) u_dp (
      .clock(clock),
      .reset(reset),
      .load (load),
      .step (step),
      .zero (zero),
      .op   (op_cur),
      .amag (amag),
      .bmag (bmag),
      .hi   (hi),
      .lo   (lo)
   );

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: arithmetic reference model checked every cycle
// plus directed vectors with literal results and latencies.
module tb_multdiv_ctrl;

`ifdef MULTDIV_EARLY_ZERO_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 33;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int checks = 0;
   int passes = 0;

   // reference model state
   int          m_rem = 0;
   logic        m_rdy = 1'b0;
   logic [31:0] m_res = '0;
   logic        m_exc = 1'b0;
   logic [31:0] p_res = '0;
   logic        p_exc = 1'b0;
   bit          m_live = 1'b0;

   multdiv_ctrl #(.WIDTH(32)) dut (
      .clock         (clock),
      .reset         (reset),
      .ctrl_MULT     (ctrl_MULT),
      .ctrl_DIV      (ctrl_DIV),
      .data_operandA (data_operandA),
      .data_operandB (data_operandB),
      .data_result   (data_result),
      .data_exception(data_exception),
      .data_resultRDY(data_resultRDY),
      .busy          (busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act === exp)
         passes++;
      else
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Model: signed arithmetic on 64-bit values, countdown to completion.
   always @(posedge clock) begin
      m_live = 1'b1;
      if (!reset) begin
         m_rem = 0;
         m_rdy = 1'b0;
         m_res = '0;
         m_exc = 1'b0;
      end else begin
         m_rdy = 1'b0;
         if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
               m_rdy = 1'b1;
               m_res = p_res;
               m_exc = p_exc;
            end
         end else if (ctrl_MULT | ctrl_DIV) begin
            longint a;
            longint b;
            longint r;
            bit fast;
            a = longint'($signed(data_operandA));
            b = longint'($signed(data_operandB));
            if (ctrl_MULT) begin
               r = a * b;
               p_res = r[31:0];
               p_exc = (r > 64'sd2147483647) || (r < -64'sd2147483648);
               fast = (ZLAT == 1) && (a == 0 || b == 0);
            end else if (b == 0) begin
               p_res = '0;
               p_exc = 1'b1;
               fast = 1'b1;
            end else begin
               r = a / b;
               p_res = r[31:0];
               p_exc = (r == 64'sd2147483648);
               fast = (ZLAT == 1) && (a == 0);
            end
            m_rem = fast ? 1 : 33;
         end
      end
   end

   always @(negedge clock) begin
      if (m_live) begin
         chk("rdy", {31'b0, data_resultRDY}, {31'b0, m_rdy});
         chk("busy", {31'b0, busy}, {31'b0, (m_rem > 0)});
         chk("result", data_result, m_res);
         chk("exc", {31'b0, data_exception}, {31'b0, m_exc});
      end
   end

   // Caller is at a negedge; start is taken on the next rising edge.
   task automatic run_op(input bit mult, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er,
                         input logic ee, input int elat);
      int lat;
      lat = 0;
      ctrl_MULT = mult;
      ctrl_DIV = ~mult;
      data_operandA = a;
      data_operandB = b;
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = 32'hDEAD_BEEF;
      data_operandB = 32'h1234_5678;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clock);
         if (data_resultRDY) begin
            lat = i;
            break;
         end
      end
      chk("lat", lat, elat);
      chk("lit_res", data_result, er);
      chk("lit_exc", {31'b0, data_exception}, {31'b0, ee});
   endtask

   initial begin
      repeat (3) @(negedge clock);
      chk("rst_res", data_result, 32'h0);
      chk("rst_rdy", {31'b0, data_resultRDY}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      reset = 1'b1;
      @(negedge clock);

      run_op(1, 32'd7, -32'sd6, 32'hFFFF_FFD6, 1'b0, 33);
      run_op(1, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 33);
      run_op(1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 33);
      run_op(0, -32'sd7, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
      run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33);
      run_op(0, 32'd5, 32'd0, 32'h0, 1'b1, 1);
      run_op(1, 32'd3, 32'd4, 32'd12, 1'b0, 33);
      run_op(0, 32'd5, 32'd0, 32'h0, 1'b1, 1);
      run_op(0, 32'd5, 32'd0, 32'h0, 1'b1, 1);
      repeat (2) @(negedge clock);
      run_op(1, -32'sd3, -32'sd5, 32'd15, 1'b0, 33);
      run_op(0, 32'd7, -32'sd2, 32'hFFFF_FFFD, 1'b0, 33);
      run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33);
      run_op(0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 33);
      run_op(1, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, 33);
      run_op(1, 32'd0, 32'd9, 32'h0, 1'b0, ZLAT);
      run_op(0, 32'd0, 32'd5, 32'h0, 1'b0, ZLAT);
      run_op(1, 32'd12345, 32'd0, 32'h0, 1'b0, ZLAT);

      // Abort an in-flight multiply; the stray divide pulse is ignored.
      run_op(1, 32'd6, 32'd7, 32'd42, 1'b0, 33);
      @(negedge clock);
      ctrl_MULT = 1'b1;
      data_operandA = 32'd11;
      data_operandB = 32'd13;
      @(negedge clock);
      ctrl_MULT = 1'b0;
      repeat (5) @(negedge clock);
      ctrl_DIV = 1'b1;
      @(negedge clock);
      ctrl_DIV = 1'b0;
      repeat (4) @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      chk("abort_res", data_result, 32'h0);
      chk("abort_exc", {31'b0, data_exception}, 32'h0);
      chk("abort_rdy", {31'b0, data_resultRDY}, 32'h0);
      chk("abort_busy", {31'b0, busy}, 32'h0);
      reset = 1'b1;
      repeat (40) @(negedge clock);
      run_op(0, 32'd100, 32'd7, 32'd14, 1'b0, 33);
      repeat (3) @(negedge clock);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
